// File: rtl/sc_fir_pkg.sv
// Shared types and defaults for the stochastic-computing FIR sequencer.
//   sched_state_t : sequencer states (IDLE, LOAD, RUN, DONE)
//   TAPS_DEF      : default tap count
//   BS_LOG2_DEF   : default log2 bitstream length per evaluation window
package sc_fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int TAPS_DEF    = 39;
  localparam int BS_LOG2_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock : rising-edge clock
//   clr   : synchronous clear (has priority over inc)
//   inc   : increment enable; the count holds once it reaches MAX
//   cnt   : current count
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_fir_sched.sv
// Sequencer for the stochastic-computing FIR input path.
// Accepts samples over valid/ready, strobes them into the tap delay line,
// and once the line is primed runs one 2^BS_LOG2-cycle evaluation window per
// sample, driving the SNG index and accumulator controls, then holds a
// result-valid handshake until the consumer takes it.
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_ready     : sample handshake, in_data = sample
//   dl_shift_en, dl_data  : delay-line shift strobe and entry-0 value
//   sng_idx               : SNG/LFSR step index within the window
//   acc_clr, acc_en       : accumulator clear / accumulate enable
//   res_valid/res_ready   : result handshake
//   primed                : delay line holds TAPS*STRIDE valid samples
// Optional build macro SC_FIR_SCHED_PERF_EN adds stall_cnt (cycles with
// in_valid && !in_ready) and win_cnt (completed RUN windows), both 32-bit
// saturating and cleared by reset.
module sc_fir_sched
  import sc_fir_pkg::*;
#(
  parameter int N       = 8,
  parameter int TAPS    = TAPS_DEF,
  parameter int STRIDE  = 1,
  parameter int BS_LOG2 = BS_LOG2_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  output logic               dl_shift_en,
  output logic [N-1:0]       dl_data,
  output logic [BS_LOG2-1:0] sng_idx,
  output logic               acc_clr,
  output logic               acc_en,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               primed
`ifdef SC_FIR_SCHED_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        win_cnt
`endif
);

  localparam int FILL_MAX = TAPS * STRIDE;
  localparam int FW       = $clog2(FILL_MAX + 1);
  localparam logic [FW-1:0] FILL_TOP = FW'(FILL_MAX);
  localparam logic [FW-1:0] FILL_PRE = FW'(FILL_MAX - 1);

  sched_state_t state, state_next;
  logic [FW-1:0] fill;
  logic          accept;
  logic          load_fills;
  logic          idx_last;
  logic          primed_next;
  logic          load_inc;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign idx_last = (sng_idx == '1);
  assign load_inc = (state == LOAD);

  // The LOAD about to complete brings fill to its ceiling (fill saturates,
  // so an already-full line also qualifies).
  assign load_fills  = (fill >= FILL_PRE);
  assign primed_next = (state == LOAD) ? load_fills : (fill == FILL_TOP);

  sat_counter #(.W(FW), .MAX(FILL_TOP)) u_fill (
    .clock (clock),
    .clr   (reset),
    .inc   (load_inc),
    .cnt   (fill)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)     state_next = LOAD;
      LOAD: state_next = load_fills ? RUN : IDLE;
      RUN:  if (idx_last)   state_next = DONE;
      DONE: if (res_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is high for
  // exactly the cycles spent in its state.
  always_ff @(posedge clock) begin
    if (reset) begin
      dl_shift_en <= 1'b0;
      dl_data     <= '0;
      sng_idx     <= '0;
      acc_clr     <= 1'b0;
      acc_en      <= 1'b0;
      res_valid   <= 1'b0;
      primed      <= 1'b0;
    end else begin
      dl_shift_en <= (state_next == LOAD);
      acc_clr     <= (state_next == LOAD);
      acc_en      <= (state_next == RUN);
      res_valid   <= (state_next == DONE);
      primed      <= primed_next;
      if (accept) begin
        dl_data <= in_data;
      end
      if (state == RUN) begin
        sng_idx <= idx_last ? '0 : sng_idx + 1'b1;
      end
    end
  end

`ifdef SC_FIR_SCHED_PERF_EN
  logic stall_inc;
  logic win_inc;

  assign stall_inc = in_valid && !in_ready;
  assign win_inc   = (state == RUN) && idx_last;

  sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_stall (
    .clock (clock),
    .clr   (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_win (
    .clock (clock),
    .clr   (reset),
    .inc   (win_inc),
    .cnt   (win_cnt)
  );
`endif

endmodule

// File: tb/tb_sc_fir_sched.sv
// Bench for sc_fir_sched: two instances (STRIDE=1 and STRIDE=2, TAPS=3,
// BS_LOG2=3) share the stimulus; each is compared every cycle against a
// window-timeline model that tracks cycles elapsed since the last accepted
// sample.
module tb_sc_fir_sched;

  localparam int N    = 8;
  localparam int TAPS = 3;
  localparam int BSL  = 3;
  localparam int WIN  = 1 << BSL;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         res_ready;

  logic           in_ready0, dl_shift_en0, acc_clr0, acc_en0, res_valid0, primed0;
  logic [N-1:0]   dl_data0;
  logic [BSL-1:0] sng_idx0;
  logic           in_ready1, dl_shift_en1, acc_clr1, acc_en1, res_valid1, primed1;
  logic [N-1:0]   dl_data1;
  logic [BSL-1:0] sng_idx1;
  logic [31:0]    stall_cnt0, win_cnt0, stall_cnt1, win_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance
  int  m_max   [2];
  bit  m_idle  [2];
  int  m_age   [2];
  int  m_fill  [2];
  bit  m_ev    [2];
  int  m_dl    [2];
  longint m_stall [2];
  longint m_win   [2];

  always #5 clock = ~clock;

  sc_fir_sched #(.N(N), .TAPS(TAPS), .STRIDE(1), .BS_LOG2(BSL)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .dl_shift_en(dl_shift_en0), .dl_data(dl_data0),
    .sng_idx(sng_idx0), .acc_clr(acc_clr0), .acc_en(acc_en0),
    .res_valid(res_valid0), .res_ready(res_ready), .primed(primed0)
`ifdef SC_FIR_SCHED_PERF_EN
    , .stall_cnt(stall_cnt0), .win_cnt(win_cnt0)
`endif
  );

  sc_fir_sched #(.N(N), .TAPS(TAPS), .STRIDE(2), .BS_LOG2(BSL)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .dl_shift_en(dl_shift_en1), .dl_data(dl_data1),
    .sng_idx(sng_idx1), .acc_clr(acc_clr1), .acc_en(acc_en1),
    .res_valid(res_valid1), .res_ready(res_ready), .primed(primed1)
`ifdef SC_FIR_SCHED_PERF_EN
    , .stall_cnt(stall_cnt1), .win_cnt(win_cnt1)
`endif
  );

`ifndef SC_FIR_SCHED_PERF_EN
  assign stall_cnt0 = '0;
  assign win_cnt0   = '0;
  assign stall_cnt1 = '0;
  assign win_cnt1   = '0;
`endif

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic step(input int i);
    if (reset) begin
      m_idle[i] = 1; m_age[i] = 0; m_fill[i] = 0; m_ev[i] = 0; m_dl[i] = 0;
      m_stall[i] = 0; m_win[i] = 0;
      return;
    end
    if (in_valid && !m_idle[i]) m_stall[i]++;
    if (m_idle[i]) begin
      if (in_valid) begin
        m_idle[i] = 0;
        m_age[i]  = 1;
        m_dl[i]   = int'(in_data);
      end
    end else if (m_age[i] == 1) begin
      m_fill[i] = (m_fill[i] + 1 > m_max[i]) ? m_max[i] : m_fill[i] + 1;
      m_ev[i]   = (m_fill[i] == m_max[i]);
      if (m_ev[i]) m_age[i] = 2;
      else         m_idle[i] = 1;
    end else if (m_age[i] <= 1 + WIN) begin
      if (m_age[i] == 1 + WIN) m_win[i]++;
      m_age[i]++;
    end else if (res_ready) begin
      m_idle[i] = 1;
    end
  endtask

  task automatic check_out(input int i, input logic rdy, input logic sh,
                           input logic [N-1:0] dd, input logic [BSL-1:0] idx,
                           input logic clr, input logic en, input logic rv,
                           input logic pr, input logic [31:0] sc,
                           input logic [31:0] wc);
    bit busy, run;
    busy = !m_idle[i];
    run  = busy && m_ev[i] && m_age[i] >= 2 && m_age[i] <= 1 + WIN;
    chk($sformatf("i%0d in_ready", i), rdy, m_idle[i] && !reset);
    chk($sformatf("i%0d dl_shift_en", i), sh, busy && m_age[i] == 1);
    chk($sformatf("i%0d acc_clr", i), clr, busy && m_age[i] == 1);
    chk($sformatf("i%0d acc_en", i), en, run);
    chk($sformatf("i%0d sng_idx", i), idx, run ? m_age[i] - 2 : 0);
    chk($sformatf("i%0d res_valid", i), rv, busy && m_ev[i] && m_age[i] >= 2 + WIN);
    chk($sformatf("i%0d primed", i), pr, m_fill[i] == m_max[i]);
    chk($sformatf("i%0d dl_data", i), dd, m_dl[i]);
`ifdef SC_FIR_SCHED_PERF_EN
    chk($sformatf("i%0d stall_cnt", i), sc, m_stall[i]);
    chk($sformatf("i%0d win_cnt", i), wc, m_win[i]);
`else
    if (sc != 0 || wc != 0) chk("perf_absent", 1, 0);
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    step(0);
    step(1);
    @(negedge clock);
    check_out(0, in_ready0, dl_shift_en0, dl_data0, sng_idx0, acc_clr0, acc_en0,
              res_valid0, primed0, stall_cnt0, win_cnt0);
    check_out(1, in_ready1, dl_shift_en1, dl_data1, sng_idx1, acc_clr1, acc_en1,
              res_valid1, primed1, stall_cnt1, win_cnt1);
  endtask

  initial begin
    int k;
    m_max[0] = TAPS * 1;
    m_max[1] = TAPS * 2;
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1; m_age[i] = 0; m_fill[i] = 0; m_ev[i] = 0; m_dl[i] = 0;
      m_stall[i] = 0; m_win[i] = 0;
    end
    reset = 1; in_valid = 0; in_data = '0; res_ready = 0;

    // Reset state
    repeat (3) cycle();
    reset = 0;
    cycle();

    // Continuous stream: priming, then back-to-back windows
    in_valid = 1; res_ready = 1;
    for (int c = 0; c < 70; c++) begin
      in_data = N'($urandom);
      cycle();
    end

    // Back-pressure in DONE
    res_ready = 0;
    for (k = 0; k < 100 && !(!m_idle[0] && m_ev[0] && m_age[0] >= 2 + WIN); k++) begin
      in_data = N'($urandom);
      cycle();
    end
    chk("reach_done", k < 100, 1);
    repeat (5) cycle();
    res_ready = 1;
    for (int c = 0; c < 6; c++) begin
      in_data = N'($urandom);
      cycle();
    end

    // Reset in the middle of a window (sng_idx == 4)
    for (k = 0; k < 100 && !(!m_idle[0] && m_ev[0] && m_age[0] == 6); k++) begin
      in_data = N'($urandom);
      cycle();
    end
    chk("reach_idx4", k < 100, 1);
    chk("idx4_seen", sng_idx0, 4);
    reset = 1;
    cycle();
    reset = 0;
    for (int c = 0; c < 40; c++) begin
      in_data = N'($urandom);
      cycle();
    end

    // Randomised handshakes with occasional reset
    for (int c = 0; c < 700; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      res_ready = ($urandom_range(0, 9) < 7);
      in_data   = N'($urandom);
      reset     = ($urandom_range(0, 249) == 0);
      cycle();
    end
    reset = 0;

    // Full window with in_valid held high
    in_valid = 1; res_ready = 1;
    for (int c = 0; c < 40; c++) begin
      in_data = N'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
